// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing single-port data_mem between the core and a host port.
// Round-robin with a bounded hold, plus a host lock that gives the host exclusive access.
module dmem_arbiter #(
  parameter int unsigned AW       = 8,
  parameter int unsigned DW       = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic          CLK,
  input  logic          start,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic          core_gnt,
  output logic          core_rvalid,
  output logic [DW-1:0] core_rdata,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  input  logic          host_lock,
  output logic          host_gnt,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wen,
  output logic          mem_ren,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [15:0]   stall_cnt
);

  typedef enum logic [1:0] {OwnNone, OwnCore, OwnHost} owner_e;

  localparam logic [3:0] HoldCnt = 4'(MAX_HOLD);

  owner_e        owner_q, owner_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          last_host_q, last_host_d;
  logic          core_rvalid_q, core_rvalid_d;
  logic          host_rvalid_q, host_rvalid_d;
  logic [DW-1:0] core_rdata_q, core_rdata_d;
  logic [DW-1:0] host_rdata_q, host_rdata_d;
  logic [15:0]   stall_q, stall_d;
  logic          core_gnt_c, host_gnt_c;
  logic [3:0]    cnt_inc;

  // Grants are masked while reset is held so every output reads 0 during reset.
  always_comb begin
    core_gnt_c = 1'b0;
    host_gnt_c = 1'b0;
    if (!start) begin
      if (host_lock) begin
        host_gnt_c = host_req;
      end else if (core_req && host_req) begin
        if (owner_q == OwnCore && cnt_q < HoldCnt) begin
          core_gnt_c = 1'b1;
        end else if (owner_q == OwnHost && cnt_q < HoldCnt) begin
          host_gnt_c = 1'b1;
        end else if (last_host_q) begin
          core_gnt_c = 1'b1;
        end else begin
          host_gnt_c = 1'b1;
        end
      end else begin
        core_gnt_c = core_req;
        host_gnt_c = host_req;
      end
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wen   = 1'b0;
    mem_ren   = 1'b0;
    if (core_gnt_c) begin
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
      mem_wen   = core_we;
      mem_ren   = ~core_we;
    end else if (host_gnt_c) begin
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
      mem_wen   = host_we;
      mem_ren   = ~host_we;
    end
  end

  always_comb begin
    cnt_inc       = (cnt_q == 4'hF) ? 4'hF : cnt_q + 4'd1;
    owner_d       = OwnNone;
    cnt_d         = 4'd0;
    last_host_d   = last_host_q;
    if (core_gnt_c) begin
      owner_d     = OwnCore;
      cnt_d       = (owner_q == OwnCore) ? cnt_inc : 4'd1;
      last_host_d = 1'b0;
    end else if (host_gnt_c) begin
      owner_d     = OwnHost;
      cnt_d       = (owner_q == OwnHost) ? cnt_inc : 4'd1;
      last_host_d = 1'b1;
    end

    core_rvalid_d = core_gnt_c & ~core_we;
    host_rvalid_d = host_gnt_c & ~host_we;
    core_rdata_d  = core_rvalid_d ? mem_rdata : core_rdata_q;
    host_rdata_d  = host_rvalid_d ? mem_rdata : host_rdata_q;

    stall_d = stall_q;
    if (((core_req & ~core_gnt_c) | (host_req & ~host_gnt_c)) && stall_q != 16'hFFFF) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge CLK or posedge start) begin
    if (start) begin
      owner_q       <= OwnNone;
      cnt_q         <= 4'd0;
      last_host_q   <= 1'b1;
      core_rvalid_q <= 1'b0;
      host_rvalid_q <= 1'b0;
      core_rdata_q  <= '0;
      host_rdata_q  <= '0;
      stall_q       <= 16'd0;
    end else begin
      owner_q       <= owner_d;
      cnt_q         <= cnt_d;
      last_host_q   <= last_host_d;
      core_rvalid_q <= core_rvalid_d;
      host_rvalid_q <= host_rvalid_d;
      core_rdata_q  <= core_rdata_d;
      host_rdata_q  <= host_rdata_d;
      stall_q       <= stall_d;
    end
  end

  assign core_gnt    = core_gnt_c;
  assign host_gnt    = host_gnt_c;
  assign core_rvalid = core_rvalid_q;
  assign host_rvalid = host_rvalid_q;
  assign core_rdata  = core_rdata_q;
  assign host_rdata  = host_rdata_q;
  assign stall_cnt   = stall_q;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data_mem between two requesters:
  - the processor core's load/store path;
  - a host port used by the bench/loader to preload operands and read back results.
- Sits between the requesters and data_mem, replacing the core's direct connection to the memory.
- Arbitration is round-robin, with a bounded hold so that neither requester can starve the other.
- Host lock mode lets the host own the memory exclusively while the program is loaded or results are dumped.

Parameters:
AW, 8, address width (matches 8-bit DataAddress)
DW, 8, data width
MAX_HOLD, 4, max consecutive grants to one requester while the other is requesting (legal range 1..15)

Ports:
CLK  input  1  clock, posedge
start  input  1  reset, asynchronous, active-high
core_req  input  1  core access request
core_we  input  1  core write (1) / read (0)
core_addr  input  AW  core address
core_wdata  input  DW  core write data
core_gnt  output  1  core access performed this cycle
core_rvalid  output  1  core read data valid (cycle after read grant)
core_rdata  output  DW  core read data
host_req  input  1  host access request
host_we  input  1  host write/read
host_addr  input  AW  host address
host_wdata  input  DW  host write data
host_lock  input  1  host exclusive ownership; core never granted while high
host_gnt  output  1  host access performed this cycle
host_rvalid  output  1  host read data valid
host_rdata  output  DW  host read data
mem_addr  output  AW  to data_mem DataAddress
mem_wen  output  1  to data_mem WriteMem
mem_ren  output  1  to data_mem ReadMem
mem_wdata  output  DW  to data_mem DataIn
mem_rdata  input  DW  from data_mem DataOut (combinational read)
stall_cnt  output  16  saturating count of cycles in which some request was not granted

Behaviour:
- State registers:
  - owner: NONE/CORE/HOST, the requester granted last cycle;
  - cnt: 4-bit consecutive-grant count, saturating at 15;
  - last: most recent requester ever granted.
- Reset (start high, async): owner=NONE, cnt=0, last=HOST (so the core wins the first contended cycle). Outputs are all 0: gnt, rvalid, rdata, mem_*, stall_cnt.
- Grant is combinational from the registered state and the current requests. At most one gnt is high per cycle.
  - host_lock=1: host_gnt=host_req; core_gnt=0.
  - Only one requester active: that requester is granted.
  - Both active, owner==X and cnt<MAX_HOLD: grant X.
  - Both active, otherwise: grant the requester != last.
  - Neither active: no grant.
- Handshake:
  - A requester holds req, we, addr and wdata stable until it sees gnt.
  - Each gnt cycle is exactly one access. If req stays high after gnt, it is a new access.
- Memory side (combinational):
  - mem_addr and mem_wdata come from the granted requester.
  - mem_wen = gnt & we; mem_ren = gnt & ~we.
  - With no grant: mem_addr=0, mem_wdata=0, mem_wen=0, mem_ren=0.
- Writes commit at the posedge ending the gnt cycle.
- Reads: latency 1.
  - At that posedge, X_rdata <= mem_rdata and X_rvalid <= 1.
  - X_rvalid is 0 in any cycle not following a read grant to X.
  - X_rdata holds its last value otherwise.
- State update at each posedge:
  - Grant to X: cnt <= (owner==X) ? sat(cnt+1) : 1; owner <= X; last <= X.
  - No grant: owner <= NONE; cnt <= 0; last is unchanged.
- stall_cnt increments when (core_req & ~core_gnt) | (host_req & ~host_gnt). It saturates at 16'hFFFF.
- MAX_HOLD=1 gives strict alternation under contention.
- A write by one requester followed by a read of the same address by the other requester in the next cycle returns the new data.
- Reset asserted mid-operation:
  - Any in-flight rvalid is dropped.
  - A write whose gnt cycle is cut by reset is not guaranteed to commit.
  - The arbiter restarts from the reset state.
- host_lock asserted while the core owns the memory: the core loses its grant that same cycle, and its held request accumulates stall_cnt.

Test Plan:
- Reset, then core writes 8'h5A to addr 8'h10 (no contention) → core_gnt=1, mem_wen=1, mem_addr=10 the same cycle. A following core read → core_rvalid=1, core_rdata=5A one cycle after its gnt.
- Both requesters held continuously from reset, MAX_HOLD=4 → grant sequence CORE×4, HOST×4, CORE×4…; stall_cnt=8 after 8 cycles.
- MAX_HOLD=1, both held → grants alternate C,H,C,H starting with CORE; each gnt is exactly 1 cycle.
- host_lock=1 with both requesting for 6 cycles → host_gnt=1 for all 6 cycles, core_gnt=0, stall_cnt=6. Dropping lock → core granted on the next contended cycle (last=HOST).
- Host writes 8'hC3 to addr 8'h20; the core reads 8'h20 in the next cycle → core_rdata=C3.
- Core read granted; start pulsed asynchronously before the next posedge → core_rvalid=0, stall_cnt=0, and the next contended cycle grants CORE.
